// File: rtl/datapath_trace_checker_if.sv
// +----------------------------------------------------------------------------+
// | datapath_trace_checker_if : sampled PC/Instruction/ALUResult bus           |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface datapath_trace_checker_if;
  logic        sample_valid;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] ALUResult;

  modport master (output sample_valid, PC, Instruction, ALUResult);
  modport slave  (input  sample_valid, PC, Instruction, ALUResult);
endinterface

`default_nettype wire

// File: rtl/datapath_trace_checker.sv
// +----------------------------------------------------------------------------+
// | datapath_trace_checker : compares datapath samples against a golden trace  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module datapath_trace_checker #(
  parameter int                  DEPTH        = 32,
  parameter int                  IDX_W        = 5,
  parameter int                  SKIP_CYCLES  = 0,
  parameter bit                  STOP_ON_FAIL = 1'b1,
  // Entry i lives at bits [96*i +: 96], each word {PC, Instruction, ALUResult}
  parameter logic [96*DEPTH-1:0] TRACE_INIT   = '0
) (
  input  wire logic                 clock,
  input  wire logic                 Reset,
  input  wire logic                 start,
  datapath_trace_checker_if.slave   smp,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [IDX_W-1:0]          mismatch_idx,
  output logic [2:0]                mismatch_field,
  output logic [IDX_W:0]            checked_count,
  output logic [7:0]                err_count
);

  localparam int C_SKIP_W = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
  localparam logic [C_SKIP_W-1:0] c_skip_last = C_SKIP_W'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]    c_idx_last  = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SKIP  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [C_SKIP_W-1:0]   skip_q, skip_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic [IDX_W-1:0]      mismatch_idx_q, mismatch_idx_d;
  logic [2:0]            mismatch_field_q, mismatch_field_d;
  logic [IDX_W:0]        checked_count_q, checked_count_d;
  logic [7:0]            err_count_q, err_count_d;

  logic [95:0]           rom [DEPTH];
  logic [95:0]           w_exp;
  logic [2:0]            w_field;
  logic                  w_mismatch;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = TRACE_INIT[96*gi +: 96];
  end

  // Case inequality so that X/Z on the sampled bus is flagged as a mismatch
  always_comb begin
    w_exp      = rom[idx_q];
    w_field    = {smp.PC          !== w_exp[95:64],
                  smp.Instruction !== w_exp[63:32],
                  smp.ALUResult   !== w_exp[31:0]};
    w_mismatch = |w_field;
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    skip_d           = skip_q;
    mismatch_idx_d   = mismatch_idx_q;
    mismatch_field_d = mismatch_field_q;
    checked_count_d  = checked_count_q;
    err_count_d      = err_count_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          idx_d            = '0;
          skip_d           = '0;
          mismatch_idx_d   = '0;
          mismatch_field_d = '0;
          checked_count_d  = '0;
          err_count_d      = '0;
          state_d          = (SKIP_CYCLES > 0) ? S_SKIP : S_CHECK;
        end
      end
      S_SKIP: begin
        if (smp.sample_valid) begin
          if (skip_q == c_skip_last) state_d = S_CHECK;
          else                       skip_d  = skip_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (smp.sample_valid) begin
          checked_count_d = checked_count_q + 1'b1;
          if (idx_q != c_idx_last) idx_d = idx_q + 1'b1;
          if (w_mismatch) begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 1'b1;
            if (err_count_q == 8'h00) begin
              mismatch_idx_d   = idx_q;
              mismatch_field_d = w_field;
            end
          end
          if (STOP_ON_FAIL && w_mismatch) state_d = S_FAIL;
          else if (idx_q == c_idx_last)   state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flags follow the next state so they appear one cycle after the sample edge
    busy_d = (state_d == S_SKIP) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_count_d == 8'h00);
    fail_d = (state_d == S_FAIL) || (done_d && (err_count_d != 8'h00));
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      skip_q           <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      fail_q           <= 1'b0;
      mismatch_idx_q   <= '0;
      mismatch_field_q <= '0;
      checked_count_q  <= '0;
      err_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      skip_q           <= skip_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      fail_q           <= fail_d;
      mismatch_idx_q   <= mismatch_idx_d;
      mismatch_field_q <= mismatch_field_d;
      checked_count_q  <= checked_count_d;
      err_count_q      <= err_count_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign mismatch_idx   = mismatch_idx_q;
  assign mismatch_field = mismatch_field_q;
  assign checked_count  = checked_count_q;
  assign err_count      = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_trace_checker.sv
// +----------------------------------------------------------------------------+
// | tb_datapath_trace_checker : directed bench, three checker configurations   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_datapath_trace_checker;

  localparam logic [383:0] TRACE = {
    96'h0000000c_40208233_00000002,
    96'h00000008_002081b3_00000008,
    96'h00000004_00300113_00000003,
    96'h00000000_00500093_00000005
  };

  logic clock;
  logic Reset;
  logic start;
  datapath_trace_checker_if bus ();

  // Index 0: stop-on-fail, 1: count mode, 2: stop-on-fail with two skipped samples
  logic [2:0][3:0] flg;
  logic [2:0][1:0] mi;
  logic [2:0][2:0] mf;
  logic [2:0][2:0] cc;
  logic [2:0][7:0] ec;

  int n_assert = 0;
  int n_fail   = 0;

  datapath_trace_checker #(.DEPTH(4), .IDX_W(2), .SKIP_CYCLES(0), .STOP_ON_FAIL(1'b1), .TRACE_INIT(TRACE)) u_stop (
    .clock(clock), .Reset(Reset), .start(start), .smp(bus),
    .busy(flg[0][3]), .done(flg[0][2]), .pass(flg[0][1]), .fail(flg[0][0]),
    .mismatch_idx(mi[0]), .mismatch_field(mf[0]), .checked_count(cc[0]), .err_count(ec[0]));

  datapath_trace_checker #(.DEPTH(4), .IDX_W(2), .SKIP_CYCLES(0), .STOP_ON_FAIL(1'b0), .TRACE_INIT(TRACE)) u_count (
    .clock(clock), .Reset(Reset), .start(start), .smp(bus),
    .busy(flg[1][3]), .done(flg[1][2]), .pass(flg[1][1]), .fail(flg[1][0]),
    .mismatch_idx(mi[1]), .mismatch_field(mf[1]), .checked_count(cc[1]), .err_count(ec[1]));

  datapath_trace_checker #(.DEPTH(4), .IDX_W(2), .SKIP_CYCLES(2), .STOP_ON_FAIL(1'b1), .TRACE_INIT(TRACE)) u_skip (
    .clock(clock), .Reset(Reset), .start(start), .smp(bus),
    .busy(flg[2][3]), .done(flg[2][2]), .pass(flg[2][1]), .fail(flg[2][0]),
    .mismatch_idx(mi[2]), .mismatch_field(mf[2]), .checked_count(cc[2]), .err_count(ec[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] ent(int i);
    return TRACE[96*i +: 96];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected flags packed as {busy, done, pass, fail}
  task automatic st(logic [1:0] d, string tag, logic [3:0] f, logic [1:0] mi_e,
                    logic [2:0] mf_e, logic [2:0] cc_e, logic [7:0] ec_e);
    chk({tag, "/flags"}, 32'(flg[d]), 32'(f));
    chk({tag, "/mismatch_idx"}, 32'(mi[d]), 32'(mi_e));
    chk({tag, "/mismatch_field"}, 32'(mf[d]), 32'(mf_e));
    chk({tag, "/checked_count"}, 32'(cc[d]), 32'(cc_e));
    chk({tag, "/err_count"}, 32'(ec[d]), 32'(ec_e));
  endtask

  task automatic send(logic v, logic [95:0] w);
    bus.sample_valid = v;
    {bus.PC, bus.Instruction, bus.ALUResult} = w;
    @(posedge clock);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    send(1'b0, '0);
    start = 1'b0;
  endtask

  initial begin
    logic [95:0] w;
    Reset = 1'b0;
    start = 1'b0;
    bus.sample_valid = 1'b0;
    {bus.PC, bus.Instruction, bus.ALUResult} = '0;
    repeat (2) @(posedge clock);
    #1;
    st(2'd0, "reset_stop", 4'b0000, 2'd0, 3'b000, 3'd0, 8'd0);
    st(2'd2, "reset_skip", 4'b0000, 2'd0, 3'b000, 3'd0, 8'd0);
    Reset = 1'b1;
    send(1'b0, '0);

    // Golden run
    arm();
    st(2'd0, "t1_armed_stop", 4'b1000, 2'd0, 3'b000, 3'd0, 8'd0);
    st(2'd2, "t1_armed_skip", 4'b1000, 2'd0, 3'b000, 3'd0, 8'd0);
    for (int i = 0; i < 3; i++) send(1'b1, ent(i));
    st(2'd0, "t1_after3", 4'b1000, 2'd0, 3'b000, 3'd3, 8'd0);
    send(1'b1, ent(3));
    st(2'd0, "t1_done_stop", 4'b0110, 2'd0, 3'b000, 3'd4, 8'd0);
    st(2'd1, "t1_done_count", 4'b0110, 2'd0, 3'b000, 3'd4, 8'd0);
    st(2'd2, "t1_skip_misaligned", 4'b0001, 2'd0, 3'b111, 3'd1, 8'd1);

    // Entry 2 ALUResult off by one
    arm();
    send(1'b1, ent(0));
    send(1'b1, ent(1));
    w = ent(2);
    w[31:0] = w[31:0] + 32'd1;
    send(1'b1, w);
    st(2'd0, "t2_fail_stop", 4'b0001, 2'd2, 3'b001, 3'd3, 8'd1);
    send(1'b1, ent(3));
    st(2'd0, "t2_hold_stop", 4'b0001, 2'd2, 3'b001, 3'd3, 8'd1);
    st(2'd1, "t2_done_count", 4'b0101, 2'd2, 3'b001, 3'd4, 8'd1);

    // PC wrong at entries 1 and 3
    arm();
    for (int i = 0; i < 4; i++) begin
      w = ent(i);
      if (i == 1 || i == 3) w[95:64] = w[95:64] ^ 32'd1;
      send(1'b1, w);
    end
    st(2'd1, "t3_count", 4'b0101, 2'd1, 3'b100, 3'd4, 8'd2);
    st(2'd0, "t3_stop", 4'b0001, 2'd1, 3'b100, 3'd2, 8'd1);

    // Skip and gaps; the start edge also carries a valid sample that must be ignored
    start = 1'b1;
    send(1'b1, '1);
    start = 1'b0;
    send(1'b1, '1);
    send(1'b0, '1);
    send(1'b1, '1);
    st(2'd2, "t4_skipped", 4'b1000, 2'd0, 3'b000, 3'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, '1);
      send(1'b1, ent(i));
    end
    st(2'd2, "t4_after3", 4'b1000, 2'd0, 3'b000, 3'd3, 8'd0);
    send(1'b0, '1);
    send(1'b1, ent(3));
    st(2'd2, "t4_done_skip", 4'b0110, 2'd0, 3'b000, 3'd4, 8'd0);

    // Unknown Instruction on entry 0
    arm();
    w = ent(0);
    w[63:32] = 'x;
    send(1'b1, w);
    st(2'd0, "t5_x_instr", 4'b0001, 2'd0, 3'b010, 3'd1, 8'd1);

    // Reset mid-CHECK, then replay with a start pulse ignored while checking
    arm();
    send(1'b1, ent(0));
    bus.sample_valid = 1'b1;
    {bus.PC, bus.Instruction, bus.ALUResult} = ent(1);
    #3;
    Reset = 1'b0;
    #1;
    st(2'd0, "t6_in_reset_stop", 4'b0000, 2'd0, 3'b000, 3'd0, 8'd0);
    st(2'd1, "t6_in_reset_count", 4'b0000, 2'd0, 3'b000, 3'd0, 8'd0);
    bus.sample_valid = 1'b0;
    @(posedge clock);
    #1;
    Reset = 1'b1;
    send(1'b0, '0);
    arm();
    send(1'b1, ent(0));
    start = 1'b1;
    send(1'b1, ent(1));
    start = 1'b0;
    send(1'b1, ent(2));
    send(1'b1, ent(3));
    st(2'd0, "t6_replay_stop", 4'b0110, 2'd0, 3'b000, 3'd4, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
